// File: rtl/cpu_debug_link.sv
// ---------------------------------------------------------------------------
// cpu_debug_link
//
// Host-side command controller between a word-level UART RX/TX pair and a
// CPU core. Command words arriving on rx_* are decoded into CPU reset,
// free-run and N-cycle step control, or into read-back requests (PC, status,
// probe). Every reply leaves through the single tx_valid/tx_data register.
//
// Opcodes: 1 RESET, 2 STATUS, 3 READ_PC, 4 RUN, 5 HALT,
//          6 STEP (argument word = N), 7 READ_PROBE (argument word = index).
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   rx_valid    1-cycle strobe, new word on rx_data
//   rx_data     received word (DATA_W)
//   tx_valid    response word pending
//   tx_data     response word, stable while tx_valid
//   tx_ready    transmitter accepts word when tx_valid & tx_ready
//   pc          current CPU program counter
//   probe_data  NUM_PROBES packed probe words, probe k at [k*DATA_W +: DATA_W]
//   cpu_reset   CPU reset, active-high
//   cpu_run     CPU clock enable (level)
//   busy        high whenever the controller is not idle
//
// Build option
//   CPU_DEBUG_LINK_TIMEOUT_EN : when defined, an argument that does not arrive
//   within ARG_TIMEOUT cycles aborts the command with ERR_CODE. When
//   undefined, the controller waits for the argument indefinitely and the
//   counter is not built.
// ---------------------------------------------------------------------------
module cpu_debug_link #(
  parameter int                DATA_W       = 32,
  parameter int                NUM_PROBES   = 4,
  parameter int                RESET_CYCLES = 4,
  parameter logic [DATA_W-1:0] READY_CODE   = DATA_W'(3),
  parameter logic [DATA_W-1:0] ERR_CODE     = '1,
  parameter int                ARG_TIMEOUT  = 1_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         rx_valid,
  input  logic [DATA_W-1:0]            rx_data,
  output logic                         tx_valid,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_ready,
  input  logic [DATA_W-1:0]            pc,
  input  logic [NUM_PROBES*DATA_W-1:0] probe_data,
  output logic                         cpu_reset,
  output logic                         cpu_run,
  output logic                         busy
);

  // Elaboration-time guard against unusable parameter combinations.
  if (DATA_W < 16 || NUM_PROBES < 1 || RESET_CYCLES < 1 || ARG_TIMEOUT < 1) begin : g_param_check
    $error("cpu_debug_link: illegal parameter value");
  end

  localparam logic [DATA_W-1:0] OP_RESET      = DATA_W'(1);
  localparam logic [DATA_W-1:0] OP_STATUS     = DATA_W'(2);
  localparam logic [DATA_W-1:0] OP_READ_PC    = DATA_W'(3);
  localparam logic [DATA_W-1:0] OP_RUN        = DATA_W'(4);
  localparam logic [DATA_W-1:0] OP_HALT       = DATA_W'(5);
  localparam logic [DATA_W-1:0] OP_STEP       = DATA_W'(6);
  localparam logic [DATA_W-1:0] OP_READ_PROBE = DATA_W'(7);

  localparam logic [DATA_W-1:0] NUM_PROBES_W = DATA_W'(NUM_PROBES);

  // Probe selector is a power-of-two table; slots past NUM_PROBES read zero
  // and are never returned because the index is range-checked first.
  localparam int IDX_W       = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1;
  localparam int PROBE_SLOTS = 1 << IDX_W;

  localparam int             RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES - 1);

`ifdef CPU_DEBUG_LINK_TIMEOUT_EN
  localparam int             TMO_W    = (ARG_TIMEOUT > 1) ? $clog2(ARG_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ARG_TIMEOUT - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG_WAIT,
    ST_RESET_CPU,
    ST_STEP_CPU,
    ST_RESP
  } state_t;

  state_t            state_reg,    state_next;
  logic              arg_step_reg, arg_step_next;  // 1: STEP awaits N, 0: READ_PROBE awaits index
  logic [DATA_W-1:0] resp_reg,     resp_next;
  logic              run_mode_reg, run_mode_next;
  logic              overrun_reg,  overrun_next;
  logic [DATA_W-1:0] step_cnt_reg, step_cnt_next;
  logic [RST_W-1:0]  rst_cnt_reg,  rst_cnt_next;
`ifdef CPU_DEBUG_LINK_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_cnt_reg,  tmo_cnt_next;
`endif

  logic [DATA_W-1:0] probe_arr [PROBE_SLOTS];
  logic [DATA_W-1:0] probe_sel;

  generate
    for (genvar gi = 0; gi < PROBE_SLOTS; gi++) begin : g_probe
      if (gi < NUM_PROBES) begin : g_real
        assign probe_arr[gi] = probe_data[gi*DATA_W +: DATA_W];
      end else begin : g_pad
        assign probe_arr[gi] = '0;
      end
    end
  endgenerate

  assign probe_sel = probe_arr[rx_data[IDX_W-1:0]];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      arg_step_reg <= 1'b0;
      resp_reg     <= '0;
      run_mode_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      step_cnt_reg <= '0;
      rst_cnt_reg  <= '0;
`ifdef CPU_DEBUG_LINK_TIMEOUT_EN
      tmo_cnt_reg  <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      arg_step_reg <= arg_step_next;
      resp_reg     <= resp_next;
      run_mode_reg <= run_mode_next;
      overrun_reg  <= overrun_next;
      step_cnt_reg <= step_cnt_next;
      rst_cnt_reg  <= rst_cnt_next;
`ifdef CPU_DEBUG_LINK_TIMEOUT_EN
      tmo_cnt_reg  <= tmo_cnt_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    arg_step_next = arg_step_reg;
    resp_next     = resp_reg;
    run_mode_next = run_mode_reg;
    overrun_next  = overrun_reg;
    step_cnt_next = step_cnt_reg;
    rst_cnt_next  = rst_cnt_reg;
`ifdef CPU_DEBUG_LINK_TIMEOUT_EN
    tmo_cnt_next  = tmo_cnt_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (rx_valid) begin
          // Most opcodes answer straight away; the exceptions override this.
          state_next = ST_RESP;
          case (rx_data)
            OP_RESET: begin
              state_next    = ST_RESET_CPU;
              rst_cnt_next  = '0;
              run_mode_next = 1'b0;
            end
            OP_STATUS: begin
              resp_next    = {{(DATA_W-3){1'b0}}, overrun_reg, run_mode_reg, 1'b1};
              overrun_next = 1'b0;
            end
            OP_READ_PC: begin
              resp_next = pc;
            end
            OP_RUN: begin
              run_mode_next = 1'b1;
              resp_next     = READY_CODE;
            end
            OP_HALT: begin
              run_mode_next = 1'b0;
              resp_next     = READY_CODE;
            end
            OP_STEP, OP_READ_PROBE: begin
              state_next    = ST_ARG_WAIT;
              arg_step_next = (rx_data == OP_STEP);
`ifdef CPU_DEBUG_LINK_TIMEOUT_EN
              tmo_cnt_next  = '0;
`endif
            end
            default: begin
              resp_next = ERR_CODE;
            end
          endcase
        end
      end

      ST_ARG_WAIT: begin
        if (rx_valid) begin
          state_next = ST_RESP;
          if (arg_step_reg) begin
            // Stepping a free-running CPU is meaningless: refuse, keep run_mode.
            if (run_mode_reg) begin
              resp_next = ERR_CODE;
            end else if (rx_data == '0) begin
              resp_next = READY_CODE;
            end else begin
              step_cnt_next = rx_data;
              state_next    = ST_STEP_CPU;
            end
          end else if (rx_data < NUM_PROBES_W) begin
            resp_next = probe_sel;
          end else begin
            resp_next = ERR_CODE;
          end
        end
`ifdef CPU_DEBUG_LINK_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_LAST) begin
          state_next = ST_RESP;
          resp_next  = ERR_CODE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
`endif
      end

      ST_RESET_CPU: begin
        if (rx_valid) begin
          overrun_next = 1'b1;
        end
        if (rst_cnt_reg == RST_LAST) begin
          state_next = ST_RESP;
          resp_next  = READY_CODE;
        end else begin
          rst_cnt_next = rst_cnt_reg + RST_W'(1);
        end
      end

      ST_STEP_CPU: begin
        if (rx_valid) begin
          overrun_next = 1'b1;
        end
        // Counter drains to zero on the last enabled cycle.
        step_cnt_next = step_cnt_reg - DATA_W'(1);
        if (step_cnt_reg == DATA_W'(1)) begin
          state_next = ST_RESP;
          resp_next  = READY_CODE;
        end
      end

      ST_RESP: begin
        // Any word arriving while a reply is pending is lost, including one
        // coinciding with the handshake.
        if (rx_valid) begin
          overrun_next = 1'b1;
        end
        if (tx_ready) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs (all decoded from registered state)
  // -------------------------------------------------------------------------
  assign tx_valid  = (state_reg == ST_RESP);
  assign tx_data   = resp_reg;
  assign cpu_reset = (state_reg == ST_RESET_CPU);
  assign cpu_run   = (run_mode_reg | (state_reg == ST_STEP_CPU)) & ~cpu_reset;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cpu_debug_link.sv
// ---------------------------------------------------------------------------
// tb_cpu_debug_link
//
// Self-checking bench for cpu_debug_link (DATA_W=32, NUM_PROBES=4,
// RESET_CYCLES=4, ARG_TIMEOUT=50). A command-level reference model tracks
// run mode and overrun and predicts each reply, the number of cpu_run and
// cpu_reset cycles it causes, and the levels left behind. Directed scenarios
// are followed by a randomized command stream with random backpressure and
// dropped words. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_cpu_debug_link;

  localparam int W = 32;
  localparam logic [31:0] READY = 32'd3;
  localparam logic [31:0] ERR   = 32'hFFFF_FFFF;

  logic          clk;
  logic          reset;
  logic          rx_valid;
  logic [W-1:0]  rx_data;
  logic          tx_valid;
  logic [W-1:0]  tx_data;
  logic          tx_ready;
  logic [W-1:0]  pc;
  logic [4*W-1:0] probe_data;
  logic          cpu_reset;
  logic          cpu_run;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_run = 1'b0;
  bit m_ovr = 1'b0;

  cpu_debug_link #(
    .DATA_W      (W),
    .NUM_PROBES  (4),
    .RESET_CYCLES(4),
    .READY_CODE  (READY),
    .ERR_CODE    (ERR),
    .ARG_TIMEOUT (50)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .pc         (pc),
    .probe_data (probe_data),
    .cpu_reset  (cpu_reset),
    .cpu_run    (cpu_run),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Predicts the reply of one complete command and updates the model.
  function automatic logic [31:0] model_cmd(input logic [31:0] op, input logic [31:0] arg,
                                            output int exp_run, output int exp_rst);
    logic [31:0] r;
    exp_run = 0;
    exp_rst = 0;
    case (op)
      32'd1: begin m_run = 1'b0; exp_rst = 4; r = READY; end
      32'd2: begin r = {29'd0, m_ovr, m_run, 1'b1}; m_ovr = 1'b0; end
      32'd3: r = pc;
      32'd4: begin m_run = 1'b1; r = READY; end
      32'd5: begin m_run = 1'b0; r = READY; end
      32'd6: begin
        if (m_run) r = ERR;
        else begin exp_run = int'(arg); r = READY; end
      end
      32'd7: begin
        if (arg < 32'd4) r = probe_data[int'(arg)*W +: W];
        else r = ERR;
      end
      default: r = ERR;
    endcase
    return r;
  endfunction

  task automatic send_word(input logic [31:0] w);
    rx_valid = 1'b1;
    rx_data  = w;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = $urandom;
  endtask

  // Issues one command, waits for the reply (with optional stall and a
  // dropped word during the stall), and checks everything the model predicts.
  task automatic do_cmd(input logic [31:0] op, input logic [31:0] arg, input bit skip_arg,
                        input int stall_in, input bit inject_in, output int lat);
    logic [31:0] exp;
    logic [31:0] reply;
    int exp_run, exp_rst;
    int run_cnt, rst_cnt, both_cnt, stall;
    bit inject, got;
    stall  = stall_in;
    inject = inject_in;
    lat    = -1;
    reply  = '0;
    if (skip_arg) begin
      exp = ERR; exp_run = 0; exp_rst = 0;
    end else begin
      exp = model_cmd(op, arg, exp_run, exp_rst);
    end
    send_word(op);
    pc = $urandom;  // READ_PC must have sampled already
    if (!skip_arg && (op == 32'd6 || op == 32'd7)) begin
      send_word(arg);
      probe_data = {$urandom, $urandom, $urandom, $urandom};  // probe sampled already
    end
    run_cnt = 0; rst_cnt = 0; both_cnt = 0; got = 1'b0;
    for (int cyc = 0; cyc < 400 && !got; cyc++) begin
      if (cpu_run) run_cnt++;
      if (cpu_reset) rst_cnt++;
      if (cpu_run && cpu_reset) both_cnt++;
      if (tx_valid) begin
        if (lat < 0) lat = cyc;
        if (stall > 0) begin
          check_val("hold", tx_data, exp);
          stall--;
          if (inject) begin
            rx_valid = 1'b1;
            rx_data  = $urandom_range(1, 7);
            inject   = 1'b0;
            m_ovr    = 1'b1;
          end
          @(negedge clk);
          rx_valid = 1'b0;
        end else begin
          reply = tx_data;
          check_val("reply", tx_data, exp);
          tx_ready = 1'b1;
          @(negedge clk);
          tx_ready = 1'b0;
          got = 1'b1;
        end
      end else begin
        @(negedge clk);
      end
    end
    check_val("reply_seen", {31'd0, got}, 32'd1);
    check_val("busy_after", {31'd0, busy}, 32'd0);
    check_val("run_level", {31'd0, cpu_run}, {31'd0, m_run});
    check_val("rst_cycles", rst_cnt, exp_rst);
    check_val("run_in_reset", both_cnt, 0);
    if (!m_run) check_val("run_cycles", run_cnt, exp_run);
    $display("[TB] cmd op=0x%0h arg=0x%0h reply=0x%08h exp=0x%08h lat=%0d", op, arg, reply, exp, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    reset      = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = '0;
    tx_ready   = 1'b0;
    pc         = '0;
    probe_data = '0;
    repeat (3) @(negedge clk);
    check_val("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_val("rst_tx_data", tx_data, 32'd0);
    check_val("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check_val("rst_cpu_run", {31'd0, cpu_run}, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // CPU reset pulse, then stepping
    do_cmd(32'd1, 32'd0, 1'b0, 0, 1'b0, lat);
    do_cmd(32'd6, 32'd10, 1'b0, 0, 1'b0, lat);
    do_cmd(32'd6, 32'd0, 1'b0, 0, 1'b0, lat);
    do_cmd(32'd6, 32'd1, 1'b0, 0, 1'b0, lat);

    // Step refused while free-running
    do_cmd(32'd4, 32'd0, 1'b0, 0, 1'b0, lat);
    do_cmd(32'd6, 32'd7, 1'b0, 0, 1'b0, lat);
    do_cmd(32'd5, 32'd0, 1'b0, 0, 1'b0, lat);

    // Probe reads, including an out-of-range index
    probe_data[2*W +: W] = 32'hDEADBEEF;
    do_cmd(32'd7, 32'd2, 1'b0, 0, 1'b0, lat);
    do_cmd(32'd7, 32'd4, 1'b0, 0, 1'b0, lat);
    do_cmd(32'd7, 32'd3, 1'b0, 0, 1'b0, lat);

    // Backpressure with a dropped word, then STATUS reports and clears overrun
    pc = 32'h100;
    do_cmd(32'd3, 32'd0, 1'b0, 20, 1'b1, lat);
    do_cmd(32'd2, 32'd0, 1'b0, 0, 1'b0, lat);
    do_cmd(32'd2, 32'd0, 1'b0, 0, 1'b0, lat);

    // Unknown opcodes
    do_cmd(32'd0, 32'd0, 1'b0, 0, 1'b0, lat);
    do_cmd(32'd9, 32'd0, 1'b0, 0, 1'b0, lat);

    // Reset while waiting for an argument in run mode
    do_cmd(32'd4, 32'd0, 1'b0, 0, 1'b0, lat);
    send_word(32'd7);
    @(negedge clk);
    check_val("argwait_run", {31'd0, cpu_run}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_run = 1'b0; m_ovr = 1'b0;
    check_val("abort1_run", {31'd0, cpu_run}, 32'd0);
    check_val("abort1_busy", {31'd0, busy}, 32'd0);
    check_val("abort1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    do_cmd(32'd2, 32'd0, 1'b0, 0, 1'b0, lat);

    // Reset in the middle of a step
    send_word(32'd6);
    send_word(32'd30);
    repeat (5) @(negedge clk);
    check_val("midstep_run", {31'd0, cpu_run}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_run = 1'b0; m_ovr = 1'b0;
    check_val("abort2_run", {31'd0, cpu_run}, 32'd0);
    check_val("abort2_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_val("abort2_tx_data", tx_data, 32'd0);
    check_val("abort2_busy", {31'd0, busy}, 32'd0);
    check_val("abort2_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    do_cmd(32'd2, 32'd0, 1'b0, 0, 1'b0, lat);

`ifdef CPU_DEBUG_LINK_TIMEOUT_EN
    // Missing argument: ERR after exactly 50 waiting cycles, CPU never runs
    do_cmd(32'd6, 32'd0, 1'b1, 0, 1'b0, lat);
    check_val("timeout_lat", lat, 50);
    do_cmd(32'd2, 32'd0, 1'b0, 0, 1'b0, lat);
`endif

    // Randomized command stream
    for (int i = 0; i < 60; i++) begin
      logic [31:0] op, arg;
      int sel, st;
      bit inj;
      pc         = $urandom;
      probe_data = {$urandom, $urandom, $urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel >= 8) op = 32'h100 + 32'($urandom_range(0, 255));
      else op = 32'(sel);
      if (op == 32'd6) arg = 32'($urandom_range(0, 20));
      else if (op == 32'd7) arg = 32'($urandom_range(0, 5));
      else arg = 32'd0;
      st  = $urandom_range(0, 3);
      inj = (st > 0) && ($urandom_range(0, 1) == 1);
      do_cmd(op, arg, 1'b0, st, inj, lat);
    end
    do_cmd(32'd2, 32'd0, 1'b0, 0, 1'b0, lat);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
